// File: rtl/tx_phy_len_calc_pkg.sv
// Shared TX/RX PHY length parameters: rate codes, N_DBPS table, FSM states and
// airtime constants.
package tx_phy_len_calc_pkg;

  localparam int unsigned PsduLenW = 16;
  localparam int unsigned RateW    = 8;
  localparam int unsigned NDbpsW   = 9;
  localparam int unsigned NSymW    = 15;
  localparam int unsigned PadW     = 9;
  localparam int unsigned LsigW    = 12;
  localparam int unsigned TxTimeW  = 17;
  localparam int unsigned RemW     = 20;
  localparam int unsigned HtFlagBit = 7;

  // Non-HT RATE field codes (L-SIG encoding)
  localparam logic [3:0] Rate6Mbps  = 4'hB;
  localparam logic [3:0] Rate9Mbps  = 4'hF;
  localparam logic [3:0] Rate12Mbps = 4'hA;
  localparam logic [3:0] Rate18Mbps = 4'hE;
  localparam logic [3:0] Rate24Mbps = 4'h9;
  localparam logic [3:0] Rate36Mbps = 4'hD;
  localparam logic [3:0] Rate48Mbps = 4'h8;
  localparam logic [3:0] Rate54Mbps = 4'hC;

  localparam logic [RemW-1:0]    ServiceBits    = 20'd16;
  localparam logic [RemW-1:0]    TailBits       = 20'd6;
  localparam logic [TxTimeW-1:0] PreambleNonHtUs = 17'd20;
  localparam logic [TxTimeW-1:0] PreambleHtMfUs  = 17'd36;
  localparam logic [NSymW+1:0]   LsigHtOffset    = 17'd9;
  localparam logic [LsigW-1:0]   LsigMax         = 12'd4095;
  localparam logic [NSymW-1:0]   NSymMax         = 15'h7fff;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } len_state_e;

  // Data bits per OFDM symbol; zero marks an unsupported rate.
  function automatic logic [NDbpsW-1:0] n_dbps_lookup(input logic is_ht, input logic [3:0] code);
    logic [NDbpsW-1:0] n;
    n = '0;
    if (is_ht) begin
      case (code)
        4'd0:    n = 9'd26;
        4'd1:    n = 9'd52;
        4'd2:    n = 9'd78;
        4'd3:    n = 9'd104;
        4'd4:    n = 9'd156;
        4'd5:    n = 9'd208;
        4'd6:    n = 9'd234;
        4'd7:    n = 9'd260;
        default: n = '0;
      endcase
    end else begin
      case (code)
        Rate6Mbps:  n = 9'd24;
        Rate9Mbps:  n = 9'd36;
        Rate12Mbps: n = 9'd48;
        Rate18Mbps: n = 9'd72;
        Rate24Mbps: n = 9'd96;
        Rate36Mbps: n = 9'd144;
        Rate48Mbps: n = 9'd192;
        Rate54Mbps: n = 9'd216;
        default:    n = '0;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/tx_phy_len_calc_if.sv
// Request/result bundle between a TX controller and the length calculator.
interface tx_phy_len_calc_if;
  import tx_phy_len_calc_pkg::*;

  logic                start;
  logic [PsduLenW-1:0] psdu_len;
  logic [RateW-1:0]    pkt_rate;
  logic                busy;
  logic [NSymW-1:0]    n_ofdm_sym;
  logic [PadW-1:0]     n_pad_bit;
  logic [LsigW-1:0]    lsig_len;
  logic [TxTimeW-1:0]  tx_time_us;
  logic                len_valid;
  logic                len_err;

  modport master (
    output start, psdu_len, pkt_rate,
    input  busy, n_ofdm_sym, n_pad_bit, lsig_len, tx_time_us, len_valid, len_err
  );

  modport slave (
    input  start, psdu_len, pkt_rate,
    output busy, n_ofdm_sym, n_pad_bit, lsig_len, tx_time_us, len_valid, len_err
  );

endinterface

// File: rtl/n_dbps_lut.sv
// Combinational rate-code to N_DBPS lookup, shared by the TX and RX length calculators.
module n_dbps_lut
  import tx_phy_len_calc_pkg::*;
(
  input  logic [RateW-1:0]  rate_i,
  output logic [NDbpsW-1:0] n_dbps_o
);

  // Bits [6:4] carry no meaning for either rate family.
  logic unused_rate;
  assign unused_rate = ^rate_i[6:4];

  always_comb begin
    n_dbps_o = n_dbps_lookup(rate_i[HtFlagBit], rate_i[3:0]);
  end

endmodule

// File: rtl/tx_phy_len_calc.sv
// TX length calculator: symbol count, pad bits, L-SIG LENGTH and airtime for one PSDU,
// found by repeated subtraction of N_DBPS (one symbol per cycle).
module tx_phy_len_calc
  import tx_phy_len_calc_pkg::*;
(
  input logic             clock,
  input logic             reset,
  tx_phy_len_calc_if.slave bus
);

  logic [NDbpsW-1:0]   lut_n_dbps;
  len_state_e          state_q;
  logic [NDbpsW-1:0]   n_dbps_q;
  logic                is_ht_q;
  logic [PsduLenW-1:0] psdu_len_q;
  logic [RemW-1:0]     remaining_q;
  logic [NSymW-1:0]    n_sym_q;

  logic                busy_q;
  logic                len_valid_q;
  logic                len_err_q;
  logic [NSymW-1:0]    n_ofdm_sym_q;
  logic [PadW-1:0]     n_pad_bit_q;
  logic [LsigW-1:0]    lsig_len_q;
  logic [TxTimeW-1:0]  tx_time_us_q;

  logic [RemW-1:0]     n_dbps_ext;
  logic [NSymW+1:0]    lsig_ht;
  logic [TxTimeW-1:0]  tx_time_calc;
  logic [LsigW-1:0]    lsig_calc;
  logic                lsig_ovf;

  n_dbps_lut u_n_dbps_lut (
    .rate_i   (bus.pkt_rate),
    .n_dbps_o (lut_n_dbps)
  );

  assign n_dbps_ext = {{(RemW - NDbpsW){1'b0}}, n_dbps_q};

  // 3*n_sym + 9 as shift-and-add; result fields derived from the running symbol count.
  always_comb begin
    lsig_ht = {1'b0, n_sym_q, 1'b0} + {2'b00, n_sym_q} + LsigHtOffset;
    if (is_ht_q) begin
      tx_time_calc = {n_sym_q, 2'b00} + PreambleHtMfUs;
      lsig_ovf     = lsig_ht > {{(NSymW + 2 - LsigW){1'b0}}, LsigMax};
      lsig_calc    = lsig_ht[LsigW-1:0];
    end else begin
      tx_time_calc = {n_sym_q, 2'b00} + PreambleNonHtUs;
      lsig_ovf     = psdu_len_q > {{(PsduLenW - LsigW){1'b0}}, LsigMax};
      lsig_calc    = psdu_len_q[LsigW-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      n_dbps_q     <= '0;
      is_ht_q      <= 1'b0;
      psdu_len_q   <= '0;
      remaining_q  <= '0;
      n_sym_q      <= 15'd1;
      busy_q       <= 1'b0;
      len_valid_q  <= 1'b0;
      len_err_q    <= 1'b0;
      n_ofdm_sym_q <= 15'd1;
      n_pad_bit_q  <= '0;
      lsig_len_q   <= '0;
      tx_time_us_q <= '0;
    end else begin
      len_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (lut_n_dbps == '0) begin
              len_err_q <= 1'b1;
            end else begin
              n_dbps_q    <= lut_n_dbps;
              is_ht_q     <= bus.pkt_rate[HtFlagBit];
              psdu_len_q  <= bus.psdu_len;
              remaining_q <= {1'b0, bus.psdu_len, 3'b000} + ServiceBits + TailBits;
              n_sym_q     <= 15'd1;
              busy_q      <= 1'b1;
              state_q     <= StCalc;
            end
          end
        end
        StCalc: begin
          if (remaining_q > n_dbps_ext) begin
            remaining_q <= remaining_q - n_dbps_ext;
            if (n_sym_q != NSymMax) begin
              n_sym_q <= n_sym_q + 15'd1;
            end
          end else begin
            // Results are registered here so len_valid is high during the DONE cycle.
            n_pad_bit_q  <= n_dbps_q - remaining_q[NDbpsW-1:0];
            n_ofdm_sym_q <= n_sym_q;
            tx_time_us_q <= tx_time_calc;
            lsig_len_q   <= lsig_ovf ? LsigMax : lsig_calc;
            len_err_q    <= lsig_ovf;
            len_valid_q  <= 1'b1;
            state_q      <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.len_valid  = len_valid_q;
  assign bus.len_err    = len_err_q;
  assign bus.n_ofdm_sym = n_ofdm_sym_q;
  assign bus.n_pad_bit  = n_pad_bit_q;
  assign bus.lsig_len   = lsig_len_q;
  assign bus.tx_time_us = tx_time_us_q;

endmodule

// File: tb/tb_tx_phy_len_calc.sv
// Bench for tx_phy_len_calc: directed vector table, corner sequences and random
// transactions against an arithmetic reference model.
module tb_tx_phy_len_calc;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tx_phy_len_calc_if bus ();

  tx_phy_len_calc dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0]  rate;
    logic [15:0] len;
    bit          ok;
    int          sym;
    int          pad;
    int          lsig;
    int          tx_us;
    bit          err;
  } vec_t;

  typedef struct {
    int valid_cyc;
    int err_cyc;
    bit saw_busy;
    bit err_at_valid;
    int sym;
    int pad;
    int lsig;
    int tx_us;
  } res_t;

  int checks = 0;
  int errors = 0;
  int hold_sym, hold_pad, hold_lsig, hold_tx;
  logic [7:0] rate_pool [16];
  vec_t vecs [$];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int model_ndbps(input logic [7:0] rate);
    int codes [8];
    int nonht [8];
    int ht [8];
    codes = '{11, 15, 10, 14, 9, 13, 8, 12};
    nonht = '{24, 36, 48, 72, 96, 144, 192, 216};
    ht    = '{26, 52, 78, 104, 156, 208, 234, 260};
    if (rate[7]) begin
      if (rate[3] == 1'b0) return ht[rate[2:0]];
      return 0;
    end
    for (int i = 0; i < 8; i++) if (int'(rate[3:0]) == codes[i]) return nonht[i];
    return 0;
  endfunction

  function automatic vec_t model(input logic [7:0] rate, input logic [15:0] len);
    vec_t e;
    int nd, bits, l;
    e.rate = rate; e.len = len; e.sym = 0; e.pad = 0; e.lsig = 0; e.tx_us = 0; e.err = 0;
    nd = model_ndbps(rate);
    e.ok = (nd != 0);
    if (e.ok) begin
      bits  = 16 + 8 * int'(len) + 6;
      e.sym = (bits + nd - 1) / nd;
      e.pad = e.sym * nd - bits;
      if (rate[7]) begin
        e.tx_us = 36 + 4 * e.sym;
        l       = 3 * e.sym + 9;
      end else begin
        e.tx_us = 20 + 4 * e.sym;
        l       = int'(len);
      end
      e.err  = (l > 4095);
      e.lsig = e.err ? 4095 : l;
    end
    return e;
  endfunction

  task automatic run_txn(input logic [7:0] rate, input logic [15:0] len, input int budget,
                         input bit disturb, output res_t r);
    r.valid_cyc = 0; r.err_cyc = 0; r.saw_busy = 0; r.err_at_valid = 0;
    r.sym = 0; r.pad = 0; r.lsig = 0; r.tx_us = 0;
    @(negedge clock);
    for (int w = 0; w < 8 && bus.busy; w++) @(negedge clock);
    bus.start = 1'b1; bus.pkt_rate = rate; bus.psdu_len = len;
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) begin @(posedge clock); #1; end
      if (disturb && c == 5) begin
        bus.start = 1'b1; bus.pkt_rate = 8'h80; bus.psdu_len = 16'd9999;
      end
      if (disturb && c == 6) bus.start = 1'b0;
      if (bus.busy) r.saw_busy = 1'b1;
      if (bus.len_err && r.err_cyc == 0) r.err_cyc = c;
      if (bus.len_valid) begin
        r.valid_cyc    = c;
        r.err_at_valid = bus.len_err;
        r.sym          = int'(bus.n_ofdm_sym);
        r.pad          = int'(bus.n_pad_bit);
        r.lsig         = int'(bus.lsig_len);
        r.tx_us        = int'(bus.tx_time_us);
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input vec_t e, input res_t r);
    if (e.ok) begin
      chk({tag, " latency"}, r.valid_cyc, e.sym + 1);
      chk({tag, " n_ofdm_sym"}, r.sym, e.sym);
      chk({tag, " n_pad_bit"}, r.pad, e.pad);
      chk({tag, " lsig_len"}, r.lsig, e.lsig);
      chk({tag, " tx_time_us"}, r.tx_us, e.tx_us);
      chk({tag, " len_err"}, r.err_at_valid, e.err);
      chk({tag, " early_err"}, (r.err_cyc != 0 && r.err_cyc != r.valid_cyc), 0);
      hold_sym = e.sym; hold_pad = e.pad; hold_lsig = e.lsig; hold_tx = e.tx_us;
    end else begin
      chk({tag, " err_cycle"}, r.err_cyc, 1);
      chk({tag, " no_valid"}, r.valid_cyc, 0);
      chk({tag, " no_busy"}, r.saw_busy, 0);
      chk({tag, " held_sym"}, bus.n_ofdm_sym, hold_sym);
      chk({tag, " held_pad"}, bus.n_pad_bit, hold_pad);
      chk({tag, " held_lsig"}, bus.lsig_len, hold_lsig);
      chk({tag, " held_tx"}, bus.tx_time_us, hold_tx);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " len_valid"}, bus.len_valid, 0);
    chk({tag, " len_err"}, bus.len_err, 0);
    chk({tag, " n_ofdm_sym"}, bus.n_ofdm_sym, 1);
    chk({tag, " n_pad_bit"}, bus.n_pad_bit, 0);
    chk({tag, " lsig_len"}, bus.lsig_len, 0);
    chk({tag, " tx_time_us"}, bus.tx_time_us, 0);
    hold_sym = 1; hold_pad = 0; hold_lsig = 0; hold_tx = 0;
  endtask

  initial begin
    res_t res;
    vec_t e;
    logic [7:0] r;
    logic [15:0] l;

    rate_pool = '{8'h0B, 8'h0F, 8'h0A, 8'h0E, 8'h09, 8'h0D, 8'h08, 8'h0C,
                  8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87};
    //                rate   len        ok sym    pad  lsig  tx     err
    vecs.push_back('{8'h0B, 16'd100,   1, 35,    18,  100,  160,   0});
    vecs.push_back('{8'h87, 16'd1500,  1, 47,    198, 150,  224,   0});
    vecs.push_back('{8'h0C, 16'd0,     1, 1,     194, 0,    24,    0});
    vecs.push_back('{8'h82, 16'd7,     1, 1,     0,   12,   40,    0});
    vecs.push_back('{8'h05, 16'd0,     0, 0,     0,   0,    0,     0});
    vecs.push_back('{8'h0B, 16'd5000,  1, 1668,  10,  4095, 6692,  1});
    vecs.push_back('{8'h88, 16'd10,    0, 0,     0,   0,    0,     0});
    vecs.push_back('{8'h80, 16'd65535, 1, 20166, 14,  4095, 80700, 1});

    reset = 1'b1;
    bus.start = 1'b0; bus.pkt_rate = '0; bus.psdu_len = '0;
    repeat (3) @(posedge clock);
    #1;
    chk_reset_vals("reset");
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_txn(vecs[i].rate, vecs[i].len, vecs[i].ok ? vecs[i].sym + 10 : 6, 1'b0, res);
      check_result($sformatf("vec%0d", i), vecs[i], res);
    end

    // Second start and input changes mid-CALC must not disturb the first result.
    run_txn(vecs[0].rate, vecs[0].len, vecs[0].sym + 10, 1'b1, res);
    check_result("disturb", vecs[0], res);

    // Reset in the middle of a long calculation.
    @(negedge clock);
    for (int w = 0; w < 8 && bus.busy; w++) @(negedge clock);
    bus.start = 1'b1; bus.pkt_rate = 8'h0B; bus.psdu_len = 16'd5000;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk_reset_vals("mid_reset");
    repeat (3) @(posedge clock);
    #1;
    chk("mid_reset idle_busy", bus.busy, 0);
    run_txn(vecs[1].rate, vecs[1].len, vecs[1].sym + 10, 1'b0, res);
    check_result("post_reset", vecs[1], res);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
      else r = rate_pool[$urandom_range(0, 15)];
      if ($urandom_range(0, 7) == 0) l = 16'($urandom_range(3500, 6000));
      else l = 16'($urandom_range(0, 2500));
      e = model(r, l);
      run_txn(r, l, e.ok ? e.sym + 10 : 6, 1'b0, res);
      check_result($sformatf("rnd%0d rate=%h len=%0d", i, r, l), e, res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tx_phy_len_calc.md
TX_PHY_LEN_CALC -- requirements
Module: tx_phy_len_calc

Interface
REQ-001 clock  input  1  single clock domain.
REQ-002 reset  input  1  synchronous, active-high.
REQ-003 start  input  1  one-cycle request; sampled only in IDLE.
REQ-004 psdu_len  input  16  PSDU length in bytes.
REQ-005 pkt_rate  input  8  bit7 = 1 HT, 0 non-HT; [3:0] = non-HT RATE code or HT MCS 0-7; same encoding as the RX chain.
REQ-006 busy  output  1  high from the cycle after an accepted start until the return to IDLE.
REQ-007 n_ofdm_sym  output  15  number of DATA OFDM symbols.
REQ-008 n_pad_bit  output  9  pad bits in the last symbol.
REQ-009 lsig_len  output  12  L-SIG LENGTH field value.
REQ-010 tx_time_us  output  17  packet airtime in microseconds.
REQ-011 len_valid  output  1  one-cycle pulse; the result outputs are valid from this pulse until the next accepted start.
REQ-012 len_err  output  1  one-cycle pulse flagging an invalid rate or L-SIG overflow.

Function
REQ-013 The block SHALL map pkt_rate to N_DBPS (bits per symbol):
- non-HT 0xB/0xF/0xA/0xE/0x9/0xD/0x8/0xC -> 24/36/48/72/96/144/192/216
- HT MCS0-7 -> 26/52/78/104/156/208/234/260
- any other code -> 0
REQ-014 State machine SHALL be IDLE -> CALC -> DONE -> IDLE; DONE lasts exactly one cycle.
REQ-015 IDLE with start=1:
- latch N_DBPS and psdu_len
- remaining = 16 + 8*psdu_len + 6, computed in 20 bits with no truncation
- n_sym = 1
- go to CALC
REQ-016 Start with N_DBPS=0: stay in IDLE and pulse len_err on the next cycle; outputs are not updated and len_valid does not pulse.
REQ-017 Each CALC cycle with remaining > N_DBPS: remaining -= N_DBPS; n_sym += 1, saturating at 32767.
REQ-018 CALC cycle with remaining <= N_DBPS: n_pad_bit = N_DBPS - remaining, then go to DONE.
REQ-019 An exact multiple SHALL give n_pad_bit = 0 with no extra symbol.
REQ-020 DONE outputs:
- n_ofdm_sym = n_sym
- non-HT: tx_time_us = 20 + 4*n_sym; lsig_len = psdu_len
- HT mixed-format, one HT-LTF: tx_time_us = 36 + 4*n_sym; lsig_len = 3*n_sym + 9
- pulse len_valid
REQ-021 L-SIG overflow (non-HT psdu_len > 4095, or HT 3*n_sym+9 > 4095): lsig_len = 4095 and len_err pulses together with len_valid.
REQ-022 Latency: len_valid SHALL pulse exactly n_ofdm_sym + 1 cycles after the start cycle.
REQ-023 start while busy SHALL be ignored; psdu_len and pkt_rate changes during CALC SHALL have no effect.
REQ-024 start in the cycle right after DONE SHALL be accepted normally.

Reset
REQ-025 Reset SHALL return the block to IDLE from any state, abandoning any calculation in progress.
REQ-026 Reset values: busy=0, len_valid=0, len_err=0, n_ofdm_sym=1, n_pad_bit=0, lsig_len=0, tx_time_us=0.

Structure
REQ-027 The rate codes, the N_DBPS table, the state encodings and the timing constants (20, 36, 16, 6, 4095) SHALL live in the shared common parameter package used by the RX chain.
REQ-028 The N_DBPS lookup SHALL be one combinational sub-module, n_dbps_lut, reusable by the RX length calculator.
REQ-029 No multiplier or divider in the symbol loop; 3*n_sym SHALL be computed as shift-and-add.

Verification
REQ-030 start, rate 0x0B, len 100 -> n_ofdm_sym=35, n_pad_bit=18, lsig_len=100, tx_time_us=160; len_valid at cycle 36.
REQ-031 start, rate 0x87, len 1500 -> n_ofdm_sym=47, n_pad_bit=198, lsig_len=150, tx_time_us=224, len_err=0.
REQ-032 rate 0x0C, len 0 -> n_ofdm_sym=1, n_pad_bit=194, len_valid at cycle 2. Then rate 0x82, len 7 -> n_ofdm_sym=1, n_pad_bit=0.
REQ-033 rate 0x05 -> len_err pulse at cycle 1, no len_valid, busy stays 0. Then rate 0x0B, len 5000 -> lsig_len=4095, len_err together with len_valid.
REQ-034 Second start during CALC is ignored and the first result is unchanged. Reset asserted mid-CALC -> all outputs at reset values; the next start completes correctly.
REQ-035 rate 0x80, len 65535 -> n_ofdm_sym=20166, tx_time_us=80700, lsig_len=4095, len_err=1; no counter wrap-around.
